// File: rtl/fas_pkg.sv
// Shared types and constants for the FIR -> FFT -> Analysis run sequencer.
package fas_pkg;

  localparam int FAS_DATA_W    = 16;
  localparam int FAS_FREQ_W    = 4;
  localparam int FAS_FRAME_LEN = 16;
  localparam int FAS_IDX_W     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FEED   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } fas_state_e;

  // run_len is the number of accepted samples; one spare bit keeps the count overflow-free.
  function automatic int fas_sample_cnt_w(input int run_len);
    return $clog2(run_len + 1) + 1;
  endfunction

endpackage

// File: rtl/fas_frame_ctrl_if.sv
// Source, FIR feed, chain event and result signals of the run sequencer.
// slave = the controller, master = the surrounding source/chain environment.
interface fas_frame_ctrl_if;
  import fas_pkg::*;

  logic                  start;
  logic                  src_valid;
  logic [FAS_DATA_W-1:0] src_data;
  logic                  src_ready;
  logic                  data_valid;
  logic [FAS_DATA_W-1:0] data;
  logic                  fir_valid;
  logic                  fft_valid;
  logic                  done;
  logic [FAS_FREQ_W-1:0] freq;
  logic                  frame_vld;
  logic [FAS_FREQ_W-1:0] frame_freq;
  logic [FAS_IDX_W-1:0]  frame_idx;
  logic                  busy;
  logic                  run_done;
  logic                  err;

  modport master (
    output start, src_valid, src_data, fir_valid, fft_valid, done, freq,
    input  src_ready, data_valid, data, frame_vld, frame_freq, frame_idx,
           busy, run_done, err
  );

  modport slave (
    input  start, src_valid, src_data, fir_valid, fft_valid, done, freq,
    output src_ready, data_valid, data, frame_vld, frame_freq, frame_idx,
           busy, run_done, err
  );

endinterface

// File: rtl/fas_evt_tracker.sv
// Tracks FFT frames against Analysis results, captures per-frame results and
// raises the sticky error for unmatched results, surplus frames or watchdog expiry.
module fas_evt_tracker
  import fas_pkg::*;
#(
  parameter int NUM_FRAMES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  active,
  input  logic                  fft_valid,
  input  logic                  done,
  input  logic [FAS_FREQ_W-1:0] freq,
  input  logic                  timeout_hit,
  output logic                  abort,
  output logic                  frame_vld,
  output logic [FAS_FREQ_W-1:0] frame_freq,
  output logic [FAS_IDX_W-1:0]  frame_idx,
  output logic [FAS_IDX_W-1:0]  frames_done,
  output logic                  err
);

  localparam logic [FAS_IDX_W:0] FRAMES_MAX = (FAS_IDX_W+1)'(NUM_FRAMES);

  logic [FAS_IDX_W-1:0]  outstanding_q;
  logic [FAS_IDX_W-1:0]  frames_done_q;
  logic                  frame_vld_q;
  logic [FAS_FREQ_W-1:0] frame_freq_q;
  logic [FAS_IDX_W-1:0]  frame_idx_q;
  logic                  err_q;
  logic [FAS_IDX_W:0]    frames_seen;
  logic                  done_err;
  logic                  fft_err;

  // Every FFT frame seen this run is either still outstanding or already reported.
  assign frames_seen = {1'b0, frames_done_q} + {1'b0, outstanding_q};
  assign done_err    = active && done && (outstanding_q == '0);
  assign fft_err     = active && fft_valid && (frames_seen >= FRAMES_MAX);
  assign abort       = done_err || fft_err || timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_q <= '0;
      frames_done_q <= '0;
      frame_vld_q   <= 1'b0;
      frame_freq_q  <= '0;
      frame_idx_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      frame_vld_q <= 1'b0;
      if (clear) begin
        outstanding_q <= '0;
        frames_done_q <= '0;
        err_q         <= 1'b0;
      end else if (abort) begin
        err_q <= 1'b1;
      end else if (active) begin
        if (fft_valid && !done) begin
          outstanding_q <= outstanding_q + 1'b1;
        end else if (done && !fft_valid) begin
          outstanding_q <= outstanding_q - 1'b1;
        end
        if (done) begin
          frame_vld_q   <= 1'b1;
          frame_freq_q  <= freq;
          frame_idx_q   <= frames_done_q;
          frames_done_q <= frames_done_q + 1'b1;
        end
      end
    end
  end

  assign frame_vld   = frame_vld_q;
  assign frame_freq  = frame_freq_q;
  assign frame_idx   = frame_idx_q;
  assign frames_done = frames_done_q;
  assign err         = err_q;

endmodule

// File: rtl/fas_frame_ctrl.sv
// Run sequencer for the FIR -> FFT -> Analysis chain: feeds one run of samples
// and follows frame/result events. Optional watchdog: define FAS_CTRL_TIMEOUT_EN.
//
//  state  | meaning
//  IDLE   | waiting for start; chain events ignored
//  FEED   | accepting source samples and forwarding them to the FIR
//  DRAIN  | all samples sent; waiting for the remaining frame results
//  FINISH | one cycle, run_done pulse
module fas_frame_ctrl
  import fas_pkg::*;
#(
  parameter int FRAME_LEN  = FAS_FRAME_LEN,
  parameter int NUM_FRAMES = 4,
  parameter int FIR_TAPS   = 32,
  parameter int TIMEOUT    = 1024
) (
  input logic             clk,
  input logic             rst,
  fas_frame_ctrl_if.slave bus
);

  localparam int RUN_LEN = NUM_FRAMES * FRAME_LEN + FIR_TAPS - 1;
  localparam int SCNT_W  = fas_sample_cnt_w(RUN_LEN);
  localparam int FCNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FAS_IDX_W-1:0] FRAMES_END = FAS_IDX_W'(NUM_FRAMES);

  fas_state_e            state_q;
  fas_state_e            state_d;
  logic [SCNT_W-1:0]     remain_q;
  logic [FCNT_W-1:0]     fir_cnt_q;
  logic                  data_valid_q;
  logic [FAS_DATA_W-1:0] data_q;
  logic                  src_ready;
  logic                  busy;
  logic                  run_done;
  logic                  active;
  logic                  start_acc;
  logic                  accept;
  logic                  last_accept;
  logic                  timeout_hit;
  logic                  abort;
  logic [FAS_IDX_W-1:0]  frames_done;

  assign start_acc   = (state_q == IDLE) && bus.start;
  assign accept      = bus.src_valid && src_ready;
  assign last_accept = accept && (remain_q == SCNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_ready = 1'b0;
    busy      = 1'b0;
    run_done  = 1'b0;
    active    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = FEED;
      end
      FEED: begin
        src_ready = 1'b1;
        busy      = 1'b1;
        active    = 1'b1;
        if (abort) state_d = IDLE;
        else if (last_accept) state_d = DRAIN;
      end
      DRAIN: begin
        busy   = 1'b1;
        active = 1'b1;
        if (abort) state_d = IDLE;
        else if (frames_done == FRAMES_END) state_d = FINISH;
      end
      FINISH: begin
        busy     = 1'b1;
        run_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Remaining-sample down-counter: the accept that finds 1 left is the last of the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      remain_q     <= '0;
      fir_cnt_q    <= '0;
      data_valid_q <= 1'b0;
      data_q       <= '0;
    end else begin
      data_valid_q <= accept;
      if (accept) data_q <= bus.src_data;

      if (start_acc) remain_q <= SCNT_W'(RUN_LEN);
      else if (accept) remain_q <= remain_q - 1'b1;

      if (start_acc) begin
        fir_cnt_q <= '0;
      end else if (active && bus.fir_valid) begin
        fir_cnt_q <= (fir_cnt_q == FCNT_W'(FRAME_LEN - 1)) ? '0 : fir_cnt_q + 1'b1;
      end
    end
  end

`ifdef FAS_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q;
  logic            activity;

  // Expires on the TIMEOUT-th consecutive quiet cycle in FEED/DRAIN.
  assign activity    = bus.fir_valid || bus.fft_valid || bus.done || accept;
  assign timeout_hit = active && !activity && (wd_q == WD_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else if (start_acc || (active && activity)) begin
      wd_q <= WD_W'(TIMEOUT);
    end else if (active && (wd_q != '0)) begin
      wd_q <= wd_q - 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  fas_evt_tracker #(
    .NUM_FRAMES (NUM_FRAMES)
  ) u_evt_tracker (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_acc),
    .active      (active),
    .fft_valid   (bus.fft_valid),
    .done        (bus.done),
    .freq        (bus.freq),
    .timeout_hit (timeout_hit),
    .abort       (abort),
    .frame_vld   (bus.frame_vld),
    .frame_freq  (bus.frame_freq),
    .frame_idx   (bus.frame_idx),
    .frames_done (frames_done),
    .err         (bus.err)
  );

  assign bus.src_ready  = src_ready;
  assign bus.data_valid = data_valid_q;
  assign bus.data       = data_q;
  assign bus.busy       = busy;
  assign bus.run_done   = run_done;

endmodule

// File: tb/tb_fas_frame_ctrl.sv
// Directed bench for fas_frame_ctrl with a small FIR/FFT/Analysis chain model.
// Build with FAS_CTRL_TIMEOUT_EN to exercise the watchdog case.
module tb_fas_frame_ctrl;
  import fas_pkg::*;

  localparam int FRAME_LEN  = 16;
  localparam int NUM_FRAMES = 4;
  localparam int FIR_TAPS   = 16;
  localparam int TIMEOUT    = 64;
  localparam int RUN_LEN    = NUM_FRAMES * FRAME_LEN + FIR_TAPS - 1;
  localparam int BUDGET     = 2000;

  logic clk = 1'b0;
  logic rst;

  fas_frame_ctrl_if bus ();

  fas_frame_ctrl #(
    .FRAME_LEN  (FRAME_LEN),
    .NUM_FRAMES (NUM_FRAMES),
    .FIR_TAPS   (FIR_TAPS),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int dv_cnt;
  int fv_cnt;
  int rd_cnt;
  int exp_freq;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sval(input int i);
    return 16'((i * 1237) ^ 32'h5A5A);
  endfunction

  task automatic clr_mon(input int fq);
    dv_cnt   = 0;
    fv_cnt   = 0;
    rd_cnt   = 0;
    exp_freq = fq;
  endtask

  // Forwarded samples must follow source order; frames report in index order.
  task automatic observe();
    if (bus.data_valid) begin
      chk("fwd_data", int'(bus.data), int'(sval(dv_cnt)));
      dv_cnt++;
    end
    if (bus.frame_vld) begin
      chk("frame_idx", int'(bus.frame_idx), fv_cnt);
      chk("frame_freq", int'(bus.frame_freq), exp_freq);
      fv_cnt++;
    end
    if (bus.run_done) rd_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    bus.fir_valid = 1'b0;
    bus.fft_valid = 1'b0;
    bus.done      = 1'b0;
    bus.freq      = '0;
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_src_ready"}, int'(bus.src_ready), 0);
    chk({tag, "_data_valid"}, int'(bus.data_valid), 0);
    chk({tag, "_data"}, int'(bus.data), 0);
    chk({tag, "_frame_vld"}, int'(bus.frame_vld), 0);
    chk({tag, "_frame_freq"}, int'(bus.frame_freq), 0);
    chk({tag, "_frame_idx"}, int'(bus.frame_idx), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_run_done"}, int'(bus.run_done), 0);
    chk({tag, "_err"}, int'(bus.err), 0);
  endtask

  // One run from IDLE. With chain_on the chain model answers every frame and the
  // loop ends at run_done; without it the loop ends one cycle after the last accept.
  task automatic run(input bit toggle, input bit chain_on, input int fq);
    int k = 0, seen = 0, fir_seen = 0, fft_due = 0, done_due = 0, cyc = 0;
    clr_mon(fq);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (cyc < BUDGET && (chain_on ? (rd_cnt == 0) : (k < RUN_LEN))) begin
      bus.fir_valid = 1'b0;
      bus.fft_valid = 1'b0;
      bus.done      = 1'b0;
      if (chain_on) begin
        if (done_due > 0) begin
          done_due--;
          if (done_due == 0) begin
            bus.done = 1'b1;
            bus.freq = 4'(fq);
          end
        end
        if (fft_due > 0) begin
          fft_due--;
          if (fft_due == 0) begin
            bus.fft_valid = 1'b1;
            done_due      = 3;
          end
        end
        if (bus.data_valid) begin
          seen++;
          if (seen > FIR_TAPS - 1) begin
            bus.fir_valid = 1'b1;
            fir_seen++;
            if (fir_seen % FRAME_LEN == 0) fft_due = 2;
          end
        end
      end
      if (k < RUN_LEN) begin
        bus.src_valid = toggle ? !bus.src_valid : 1'b1;
        bus.src_data  = sval(k);
        if (bus.src_valid && bus.src_ready) k++;
      end else begin
        bus.src_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    chk("run_within_budget", int'(cyc < BUDGET), 1);
    bus.src_valid = 1'b0;
    bus.fir_valid = 1'b0;
    bus.fft_valid = 1'b0;
    bus.done      = 1'b0;
  endtask

  task automatic full_run_chk(input string tag, input bit toggle, input int fq);
    run(toggle, 1'b1, fq);
    repeat (3) tick();
    chk({tag, "_fwd_count"}, dv_cnt, 79);
    chk({tag, "_frames"}, fv_cnt, 4);
    chk({tag, "_run_done_count"}, rd_cnt, 1);
    chk({tag, "_err"}, int'(bus.err), 0);
    chk({tag, "_busy_after"}, int'(bus.busy), 0);
    chk({tag, "_last_data"}, int'(bus.data), int'(sval(78)));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed time %0t, expected completion earlier", $time);
    $fatal(1);
  end

  initial begin
    int k;
    idle_inputs();
    clr_mon(0);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    zero_chk("reset");

    // continuous source, chain answers freq 3
    full_run_chk("cont", 1'b0, 3);

    // source valid toggling every cycle
    full_run_chk("toggle", 1'b1, 9);

    // result with no frame outstanding
    clr_mon(0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.done = 1'b1;
    bus.freq = 4'd6;
    tick();
    bus.done = 1'b0;
    chk("orphan_done_err", int'(bus.err), 1);
    chk("orphan_done_busy", int'(bus.busy), 0);
    chk("orphan_done_frame_vld", int'(bus.frame_vld), 0);
    tick();
    chk("orphan_done_frames", fv_cnt, 0);

    // frame and result in the same cycle keep one frame outstanding
    clr_mon(5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("restart_clears_err", int'(bus.err), 0);
    bus.fft_valid = 1'b1;
    tick();
    bus.done = 1'b1;
    bus.freq = 4'd5;
    tick();
    bus.fft_valid = 1'b0;
    chk("same_cycle_frames", fv_cnt, 1);
    tick();
    bus.done = 1'b0;
    chk("same_cycle_second_frame", fv_cnt, 2);
    chk("same_cycle_err", int'(bus.err), 0);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    chk("drained_done_err", int'(bus.err), 1);
    chk("drained_done_busy", int'(bus.busy), 0);
    chk("drained_done_frames", fv_cnt, 2);

    // a fifth FFT frame is one too many
    clr_mon(0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) begin
      bus.fft_valid = 1'b1;
      tick();
    end
    chk("four_frames_err", int'(bus.err), 0);
    chk("four_frames_busy", int'(bus.busy), 1);
    tick();
    bus.fft_valid = 1'b0;
    chk("extra_frame_err", int'(bus.err), 1);
    chk("extra_frame_busy", int'(bus.busy), 0);

    // reset in the middle of FEED, then a clean run
    clr_mon(0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 0;
    repeat (10) begin
      bus.src_valid = 1'b1;
      bus.src_data  = sval(k);
      k++;
      tick();
    end
    chk("pre_rst_busy", int'(bus.busy), 1);
    rst           = 1'b1;
    bus.src_valid = 1'b0;
    tick();
    rst = 1'b0;
    zero_chk("mid_rst");
    full_run_chk("after_rst", 1'b0, 7);

    // chain stalls in DRAIN
    run(1'b0, 1'b0, 0);
    bus.src_valid = 1'b0;
    chk("stall_fwd_count", dv_cnt, 79);
`ifdef FAS_CTRL_TIMEOUT_EN
    repeat (63) tick();
    chk("wd_before_err", int'(bus.err), 0);
    chk("wd_before_busy", int'(bus.busy), 1);
    tick();
    chk("wd_err", int'(bus.err), 1);
    chk("wd_busy", int'(bus.busy), 0);
    repeat (3) tick();
    chk("wd_run_done_count", rd_cnt, 0);
`else
    repeat (200) tick();
    chk("stall_busy", int'(bus.busy), 1);
    chk("stall_err", int'(bus.err), 0);
    chk("stall_run_done_count", rd_cnt, 0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("final_busy", int'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
